dbus_mem_responder: RTL
=======================

# dbus_mem_responder

Responder end of the data bus: a single-port, 64-bit-wide on-chip memory that serves `dbus_req_t` requests from the core and answers with `dbus_resp_t`. It accepts one transaction at a time, applies a fixed (optionally randomized) latency, commits byte-strobed writes, and returns full 64-bit read words. It sits opposite the core's memory stage in simulation and FPGA builds, replacing the external bus model for self-contained tests.

## Interface
- `MEM_WORDS`, 4096: memory depth in 64-bit words; power of two.
- `LATENCY`, 2: cycles from acceptance to `data_ok`; must be ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `dreq`  in  `dbus_req_t`  request: `valid`, `addr`, `size`, `strobe[7:0]`, `data[63:0]`.
- `dresp`  out  `dbus_resp_t`  response: `addr_ok`, `data_ok`, `data[63:0]`.

## Operation
- States: IDLE, WAIT.
- IDLE with `dreq.valid=1`:
  - Assert `addr_ok` combinationally.
  - Latch `addr`, `strobe`, and `data`.
  - Load the countdown with `LATENCY-1`.
  - Go to WAIT.
- WAIT: decrement the counter each cycle while `dreq.valid=1`.
  - When the counter reaches 0, assert `data_ok` for exactly one cycle, drive `dresp.data`, and return to IDLE.
- Index = latched `addr[3 +: $clog2(MEM_WORDS)]`. Upper address bits are ignored, so addresses wrap modulo `MEM_WORDS*8` bytes.
- Read: `dresp.data` is the full stored word, valid only while `data_ok=1`. It is 0 otherwise. The core extracts bytes by `addr[2:0]` and `size`.
- Write (`strobe≠0`):
  - Bytes with set strobe bits are written on the `data_ok` edge; other bytes are unchanged.
  - `dresp.data` returns the pre-write word.
- Abort: `dreq.valid` falls while in WAIT → return to IDLE next edge. No `data_ok`, no write.
- Request fields changing during WAIT are ignored; the latched values are used.
- Back-to-back: a new request may be accepted in the cycle after `data_ok`.
- `size` is not used for decoding. `strobe` is authoritative.

## Timing
- Reset values: state IDLE, counter 0, `addr_ok=0`, `data_ok=0`, `dresp.data=0`. Memory contents are not reset.
- Acceptance at cycle T → `data_ok=1` at T+`LATENCY`. Minimum request-to-request spacing is `LATENCY+1` cycles.
- `addr_ok` is high only in IDLE cycles with `valid=1`. `addr_ok` and `data_ok` are never high in the same cycle.
- Reset asserted mid-WAIT:
  - Outputs drop immediately (asynchronous).
  - The pending write is discarded.
  - The block is in IDLE after reset deasserts.

## Configuration
- `DBUS_RESP_RANDOM_DELAY_EN` defined:
  - A 16-bit LFSR (seed 16'hACE1, reset to seed, advances every cycle) adds `lfsr[1:0]` extra cycles (0–3) to each transaction.
  - The extra cycles are sampled at acceptance.
  - Latency becomes `LATENCY`..`LATENCY+3`.
- Macro undefined: no LFSR is instantiated and latency is exactly `LATENCY`.

## Structure
- Shared package `common`:
  - `dbus_req_t`, `dbus_resp_t`.
  - State enum `dmem_state_t {DMEM_IDLE, DMEM_WAIT}`.
  - `LFSR_SEED` constant.
- Sub-module `lfsr16`: clock, reset, `out[15:0]`, taps x^16+x^14+x^13+x^11+1. Instantiated only under the macro.
- Memory array is inferred inside the block. There is no separate RAM module.

## Test plan
- Write/read: write addr 0x80000010, strobe 8'hFF, data 64'h1122334455667788, then read the same address → `data_ok` 2 cycles after acceptance, data 64'h1122334455667788.
- Partial strobe: write 64'hAAAAAAAAAAAAAAAA with strobe 8'h0F over 64'h1122334455667788 → read returns 64'h11223344AAAAAAAA.
- Wrap-around: write at addr 0x0 and read at addr `MEM_WORDS*8` (0x8000) → read returns the written word.
- Abort: drop `valid` one cycle after acceptance of a write with 8'hFF → no `data_ok`, and a later read returns the old contents.
- Reset mid-WAIT: assert `reset` during WAIT → `data_ok=0` immediately, and the next request is accepted with `addr_ok=1` in the first cycle after reset.
- Random delay (macro on): 100 back-to-back reads → every latency lies within [2,5], and data always matches the model.

Source files
------------

// File: rtl/common.sv
// Shared data-bus types for the memory responder: request/response
// structs, responder FSM states and the latency-jitter LFSR seed.
package common;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic {
    DMEM_IDLE = 1'b0,
    DMEM_WAIT = 1'b1
  } dmem_state_t;

  // Replace the bytes of old_word selected by strobe with those of new_word.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_word,
                                              input logic [63:0] new_word,
                                              input logic [7:0]  strobe);
    logic [63:0] result;
    result = old_word;
    for (int b = 0; b < 8; b++) begin
      if (strobe[b]) result[8*b +: 8] = new_word[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every
// cycle from LFSR_SEED. Used only for the optional random response delay.
module lfsr16
  import common::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] out
);

  logic feedback;

  assign feedback = out[15] ^ out[13] ^ out[12] ^ out[10];

  // Shift register; reset returns it to the seed so runs are repeatable.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out <= LFSR_SEED;
    else       out <= {out[14:0], feedback};
  end

endmodule

// File: rtl/dbus_mem_responder.sv
// Data-bus memory responder: single-port 64-bit memory answering one request
// at a time after a fixed latency. Define DBUS_RESP_RANDOM_DELAY_EN to add
// 0..3 LFSR-chosen extra cycles per transaction.
module dbus_mem_responder
  import common::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 4);
  localparam logic [CNT_W-1:0] LOAD_BASE = CNT_W'(LATENCY - 1);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] extra;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] req_idx;
  logic [7:0]       strobe_q;
  logic [63:0]      wdata_q;
  logic [63:0]      rdata_q;
  logic             accept;
  logic             fire;

  logic [63:0] mem [MEM_WORDS];

  // Byte-offset and out-of-range address bits plus size are deliberately ignored.
  logic unused_req_bits;
  assign unused_req_bits = ^{dreq.size, dreq.addr[31:IDX_W+3], dreq.addr[2:0]};

  assign req_idx = dreq.addr[3 +: IDX_W];

`ifdef DBUS_RESP_RANDOM_DELAY_EN
  logic [15:0] lfsr_q;
  logic        unused_lfsr_bits;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (lfsr_q)
  );

  assign extra            = CNT_W'(lfsr_q[1:0]);
  assign unused_lfsr_bits = ^lfsr_q[15:2];
`else
  assign extra = '0;
`endif

  // Next-state and countdown: accept in IDLE, count down in WAIT, fire at zero,
  // abandon the transaction if valid drops.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      DMEM_IDLE: begin
        if (dreq.valid) begin
          accept  = 1'b1;
          cnt_d   = LOAD_BASE + extra;
          state_d = DMEM_WAIT;
        end
      end
      DMEM_WAIT: begin
        if (!dreq.valid) begin
          cnt_d   = '0;
          state_d = DMEM_IDLE;
        end else if (cnt_q == '0) begin
          fire    = 1'b1;
          state_d = DMEM_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = DMEM_IDLE;
      end
    endcase
  end

  // FSM state and countdown registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the request at acceptance; later changes on the bus are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q    <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      idx_q    <= req_idx;
      strobe_q <= dreq.strobe;
      wdata_q  <= dreq.data;
    end
  end

  // Single-port memory: read the addressed word at acceptance, commit the
  // strobed write on the data_ok edge. The two never coincide, and nothing
  // else modifies memory in between, so rdata_q is the pre-write word.
  // NOTE: the array and its read register have no reset so the memory maps onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) rdata_q <= mem[req_idx];
    if (fire)   mem[idx_q] <= merge_bytes(mem[idx_q], wdata_q, strobe_q);
  end

  // Response outputs, forced low while reset is asserted.
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = accept & ~reset;
    dresp.data_ok = fire & ~reset;
    if (fire && !reset) dresp.data = rdata_q;
  end

endmodule
